// File: rtl/imem_access_ctrl.sv
// Instruction BRAM arbiter: the program loader writes it while the CPU is held,
// and the CPU fetch path reads it once a program has been loaded.
module imem_access_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter bit BOOT_RUN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_done,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              cpu_run,
    output logic [ADDR_W:0]   words_ld
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam state_t          RESET_STATE = state_t'(BOOT_RUN ? ST_RUN : ST_IDLE);
    localparam logic [ADDR_W:0] WORDS_MAX   = {1'b1, {ADDR_W{1'b0}}};

    state_t          state_reg;
    state_t          state_next;
    logic            fetch_valid_reg;
    logic [ADDR_W:0] words_reg;
    logic [ADDR_W:0] words_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= RESET_STATE;
            fetch_valid_reg <= 1'b0;
            words_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_valid_reg <= fetch_gnt;
            words_reg       <= words_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        words_next = words_reg;
        ld_ready   = 1'b0;
        fetch_gnt  = 1'b0;
        cpu_run    = 1'b0;
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_din   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                    words_next = '0;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    bram_en   = 1'b1;
                    bram_we   = 1'b1;
                    bram_addr = ld_addr;
                    bram_din  = ld_data;
                    if (words_reg != WORDS_MAX) begin
                        words_next = words_reg + 1'b1;
                    end
                end
                // A repeated load_start is ignored here so the count keeps running.
                if (load_done) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                cpu_run   = 1'b1;
                fetch_gnt = fetch_req;
                if (fetch_req) begin
                    bram_en   = 1'b1;
                    bram_addr = fetch_addr;
                end
                if (load_start) begin
                    state_next = ST_LOAD;
                    words_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Gate the passthrough so stale BRAM output never leaks outside a valid cycle.
    assign fetch_valid = fetch_valid_reg;
    assign fetch_data  = fetch_valid_reg ? bram_dout : '0;
    assign words_ld    = words_reg;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Self-checking bench for imem_access_ctrl: directed scenarios then randomized
// traffic, compared cycle by cycle against a mode-level reference model.
module tb_imem_access_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic          load_start, load_done, ld_valid, fetch_req;
    logic [AW-1:0] ld_addr, fetch_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready, fetch_gnt, fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout = '0;
    logic          cpu_run;
    logic [AW:0]   words_ld;

    imem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BOOT_RUN(1'b0)) dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_done(load_done),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout),
        .cpu_run(cpu_run), .words_ld(words_ld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM with registered read; cleared on its first clock.
    logic [DW-1:0] bram_mem [DEPTH];
    bit            mem_cleared = 1'b0;
    always @(posedge clk) begin
        if (!mem_cleared) begin
            for (int i = 0; i < DEPTH; i++) bram_mem[i] <= '0;
            mem_cleared <= 1'b1;
        end else if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_din;
            bram_dout <= bram_mem[bram_addr];
        end
    end

    // Reference model: operating mode, expected memory image, load counter.
    logic [DW-1:0] ref_mem [DEPTH];
    string         mode;
    int            words;
    bit            exp_valid;
    logic [DW-1:0] exp_data;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string ctx);
        chk({ctx, ".ld_ready"},    ld_ready,    0);
        chk({ctx, ".fetch_gnt"},   fetch_gnt,   0);
        chk({ctx, ".fetch_valid"}, fetch_valid, 0);
        chk({ctx, ".fetch_data"},  fetch_data,  0);
        chk({ctx, ".bram_en"},     bram_en,     0);
        chk({ctx, ".bram_we"},     bram_we,     0);
        chk({ctx, ".bram_addr"},   bram_addr,   0);
        chk({ctx, ".bram_din"},    bram_din,    0);
        chk({ctx, ".cpu_run"},     cpu_run,     0);
        chk({ctx, ".words_ld"},    words_ld,    0);
    endtask

    // One clock of stimulus: drive after negedge, check combinational outputs,
    // advance the model at posedge, then check registered outputs.
    task automatic cycle(input bit ls, input bit ld, input bit lv, input int la,
                         input logic [DW-1:0] lda, input bit fr, input int fa);
        bit write, grant;
        @(negedge clk);
        load_start = ls;  load_done = ld;
        ld_valid   = lv;  ld_addr   = AW'(la);  ld_data = lda;
        fetch_req  = fr;  fetch_addr = AW'(fa);
        #1;
        write = (mode == "LOAD") && lv;
        grant = (mode == "RUN") && fr;
        chk("ld_ready",  ld_ready,  mode == "LOAD");
        chk("fetch_gnt", fetch_gnt, grant);
        chk("bram_en",   bram_en,   write || grant);
        chk("bram_we",   bram_we,   write);
        chk("bram_addr", bram_addr, write ? AW'(la) : (grant ? AW'(fa) : '0));
        chk("bram_din",  bram_din,  write ? lda : '0);
        @(posedge clk);
        #1;
        exp_valid = grant;
        if (grant) exp_data = ref_mem[fa];
        if (write) begin
            ref_mem[la] = lda;
            if (words < DEPTH) words++;
        end
        if (mode == "IDLE") begin
            if (ls) begin mode = "LOAD"; words = 0; end
        end else if (mode == "LOAD") begin
            if (ld) mode = "DRAIN";
        end else if (mode == "DRAIN") begin
            mode = "RUN";
        end else if (ls) begin
            mode = "LOAD"; words = 0;
        end
        chk("fetch_valid", fetch_valid, exp_valid);
        chk("fetch_data",  fetch_data,  exp_valid ? exp_data : '0);
        chk("cpu_run",     cpu_run,     mode == "RUN");
        chk("words_ld",    words_ld,    words);
        if (grant) $display("%0t fetch addr=%0d data=%h", $time, fa, fetch_data);
        else if (write) $display("%0t load addr=%0d data=%h words=%0d", $time, la, lda, words_ld);
    endtask

    // Assert reset part-way through the current cycle; outputs must clear at once.
    task automatic do_reset(input string ctx);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero(ctx);
        mode = "IDLE"; words = 0; exp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        $display("%0t reset pulse (%s)", $time, ctx);
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 0, '0, 0, 0);
    endtask

    logic [DW-1:0] prog [4];

    initial begin
        prog[0] = 32'h20010005; prog[1] = 32'h20020007;
        prog[2] = 32'h00221820; prog[3] = 32'hAC030000;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        mode = "IDLE"; words = 0; exp_valid = 1'b0; exp_data = '0;
        reset = 1'b0;
        load_start = 0; load_done = 0; ld_valid = 0; fetch_req = 0;
        ld_addr = '0; ld_data = '0; fetch_addr = '0;
        #2;
        chk_all_zero("por");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Fetches while idle are neither granted nor queued.
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, '0, 1, $urandom_range(0, DEPTH - 1));

        // Load four words, then DRAIN, then RUN.
        cycle(1, 0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, i, prog[i], 0, 0);
        cycle(0, 1, 0, 0, '0, 0, 0);
        idle_cycle();
        chk("run_words", words_ld, 4);

        // Back-to-back fetches.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, '0, 1, i);
        idle_cycle();

        // Grant in the load_start cycle still returns; LOAD refuses fetches.
        cycle(1, 0, 0, 0, '0, 1, 2);
        cycle(0, 0, 0, 0, '0, 1, 1);

        // Write coinciding with load_done still lands.
        cycle(0, 1, 1, 5, 32'hDEADBEEF, 0, 0);
        idle_cycle();
        cycle(0, 0, 0, 0, '0, 1, 5);
        idle_cycle();

        // Reset mid-LOAD, then reset while a read is in flight.
        cycle(1, 0, 0, 0, '0, 0, 0);
        cycle(0, 0, 1, 7, $urandom, 0, 0);
        do_reset("mid_load");
        idle_cycle();
        cycle(1, 0, 0, 0, '0, 0, 0);
        cycle(0, 1, 1, 8, $urandom, 0, 0);
        idle_cycle();
        cycle(0, 0, 0, 0, '0, 1, 8);
        do_reset("inflight");
        idle_cycle();

        // Saturation of the load counter.
        cycle(1, 0, 0, 0, '0, 0, 0);
        for (int i = 0; i < DEPTH + 6; i++) cycle(0, 0, 1, $urandom_range(0, 63), $urandom, 0, 0);
        chk("sat_words", words_ld, DEPTH);
        cycle(0, 1, 0, 0, '0, 0, 0);
        idle_cycle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("random");
            end else begin
                cycle($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 31));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
